alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter WORD, default `WORD from definitions.vh (64), operand/result datapath width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 opcode  input  11  LEGv8 opcode field, instr[31:21].
REQ-007 rn_data  input  WORD  register-file read port A.
REQ-008 rm_data  input  WORD  register-file read port B (Rt for CBZ/STUR).
REQ-009 imm  input  WORD  sign-extended immediate from decode.
REQ-010 flush  input  1  discard all held work (branch taken).
REQ-011 ex_valid  output  1  execute-stage operands/control are valid.
REQ-012 ex_ready  input  1  execute stage consumes the issued op this cycle.
REQ-013 a_out, b_out  output  WORD  ALU a_in/b_in operands.
REQ-014 alu_control  output  4  ALU operation, `ALU_* encodings from definitions.vh.
REQ-015 illegal  output  1  held op had an undecodable opcode.
REQ-016 issue_count  output  16  number of ops consumed by execute since reset.

Function
REQ-017 Decode SHALL map: ADD 10001011000 -> ALU_ADD, b=rm_data; SUB 11001011000 -> ALU_SUB, b=rm_data; AND 10001010000 -> ALU_AND, b=rm_data; ORR 10101010000 -> ALU_OR, b=rm_data; LDUR 11111000010 and STUR 11111000000 -> ALU_ADD, b=imm; CBZ 10110100xxx -> ALU_PASS, b=rm_data; a=rn_data in all cases.
REQ-018 Any other opcode SHALL issue ALU_PASS, a=0, b=0, illegal=1; it still flows through the handshake.
REQ-019 Storage SHALL be a two-entry buffer: output register plus one skid register; no combinational path from ex_ready to in_ready.
REQ-020 in_ready SHALL be 1 exactly when the skid register is empty (registered).
REQ-021 Transfer in SHALL occur when in_valid && in_ready; transfer out when ex_valid && ex_ready.
REQ-022 Empty output register: accepted op loads output register next cycle (latency 1 clk from accept to ex_valid).
REQ-023 Output register full and not consumed: accepted op loads skid register; in_ready drops next cycle.
REQ-024 Output consumed with skid full: skid moves to output register; skid empties; simultaneous accept not possible (in_ready=0).
REQ-025 Output consumed and new op accepted same cycle with skid empty: new op loads output register, ex_valid stays 1.
REQ-026 While ex_valid=1 and ex_ready=0, a_out, b_out, alu_control, illegal SHALL hold stable.
REQ-027 Order SHALL be preserved; no op dropped or duplicated except by flush.
REQ-028 flush=1 SHALL clear both entries next cycle (ex_valid=0, in_ready=1) and ignore any in_valid that cycle; issue_count still increments if an out-transfer occurs that same cycle.
REQ-029 issue_count SHALL increment by 1 per out-transfer and wrap 0xFFFF -> 0x0000.
REQ-030 When ex_valid=0, a_out, b_out SHALL be 0, alu_control ALU_PASS, illegal 0.

Reset
REQ-031 reset_n=0 at a rising edge SHALL set ex_valid=0, in_ready=1, both entries empty, a_out=0, b_out=0, alu_control=ALU_PASS, illegal=0, issue_count=0.
REQ-032 Reset SHALL take priority over flush and handshakes; ops held mid-stall are discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 ADD, rn=5, rm=3, ex_ready=1 -> next cycle ex_valid=1, a=5, b=3, alu_control=ALU_ADD, issue_count=1.
REQ-035 LDUR rn=0x100, imm=-8 -> b_out=0xFFFF_FFFF_FFFF_FFF8, ALU_ADD; opcode 0x7FF -> illegal=1, ALU_PASS, a=b=0.
REQ-036 ex_ready=0, three back-to-back ops A,B,C -> A held, B in skid, in_ready=0, C not accepted; ex_ready=1 -> A, B, then C issued in order.
REQ-037 Skid full, flush=1 -> next cycle ex_valid=0, in_ready=1; following op issues normally.
REQ-038 issue_count preset near wrap via 65535 transfers -> next transfer reads 0.
REQ-039 reset_n=0 during stall with both entries full -> all REQ-031 values next cycle.

Source files
------------

// File: rtl/alu_issue.sv
// LEGv8 ALU issue stage: decodes an instruction into ALU operands/control and
// hands it to execute through a two-entry (output + skid) elastic buffer.

package alu_issue_pkg;
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_PASS = 4'b0111
   } alu_op_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100???;
endpackage

module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int WORD = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [10:0]     opcode,
   input  logic [WORD-1:0] rn_data,
   input  logic [WORD-1:0] rm_data,
   input  logic [WORD-1:0] imm,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [WORD-1:0] a_out,
   output logic [WORD-1:0] b_out,
   output logic [3:0]      alu_control,
   output logic            illegal,
   output logic [15:0]     issue_count
);

   typedef struct packed {
      logic [WORD-1:0] a;
      logic [WORD-1:0] b;
      alu_op_t         ctl;
      logic            ill;
   } entry_t;

   entry_t      dec;
   entry_t      out_q;
   entry_t      skid_q;
   logic        out_valid;
   logic        skid_valid;
   logic [15:0] count;

   logic accept;
   logic take;
   logic out_free;
   logic load_out_skid;
   logic load_out_in;
   logic load_skid;

   // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      dec = '{a: '0, b: '0, ctl: ALU_PASS, ill: 1'b1};
      casez (opcode)
         OP_ADD:          dec = '{a: rn_data, b: rm_data, ctl: ALU_ADD,  ill: 1'b0};
         OP_SUB:          dec = '{a: rn_data, b: rm_data, ctl: ALU_SUB,  ill: 1'b0};
         OP_AND:          dec = '{a: rn_data, b: rm_data, ctl: ALU_AND,  ill: 1'b0};
         OP_ORR:          dec = '{a: rn_data, b: rm_data, ctl: ALU_OR,   ill: 1'b0};
         OP_LDUR, OP_STUR: dec = '{a: rn_data, b: imm,    ctl: ALU_ADD,  ill: 1'b0};
         OP_CBZ:          dec = '{a: rn_data, b: rm_data, ctl: ALU_PASS, ill: 1'b0};
         default:         ;
      endcase
   end

   // in_ready depends only on registered skid state, never on ex_ready.
   assign in_ready      = !skid_valid;
   assign accept        = in_valid && in_ready && !flush;
   assign take          = out_valid && ex_ready;
   assign out_free      = !out_valid || take;
   assign load_out_skid = !flush && out_free && skid_valid;
   assign load_out_in   = !flush && out_free && !skid_valid && accept;
   assign load_skid     = !flush && !out_free && accept;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         count      <= 16'd0;
      end else begin
         if (take)
            count <= count + 16'd1;
         if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
         end else begin
            if (out_free)
               out_valid <= skid_valid || accept;
            if (load_out_skid)
               skid_valid <= 1'b0;
            else if (load_skid)
               skid_valid <= 1'b1;
         end
      end
   end

   // NOTE: payload registers carry no reset; they are only observed through the valid-gated outputs.
   always_ff @(posedge clk) begin
      if (load_out_skid)
         out_q <= skid_q;
      else if (load_out_in)
         out_q <= dec;
      if (load_skid)
         skid_q <= dec;
   end

   assign ex_valid    = out_valid;
   assign a_out       = out_valid ? out_q.a   : '0;
   assign b_out       = out_valid ? out_q.b   : '0;
   assign alu_control = out_valid ? out_q.ctl : ALU_PASS;
   assign illegal     = out_valid && out_q.ill;
   assign issue_count = count;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// compared against a two-deep FIFO reference model.

module tb_alu_issue;
   localparam int WORD = 64;

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_PASS = 4'b0111;

   localparam logic [10:0] O_ADD  = 11'b10001011000;
   localparam logic [10:0] O_SUB  = 11'b11001011000;
   localparam logic [10:0] O_AND  = 11'b10001010000;
   localparam logic [10:0] O_ORR  = 11'b10101010000;
   localparam logic [10:0] O_LDUR = 11'b11111000010;
   localparam logic [10:0] O_STUR = 11'b11111000000;
   localparam logic [10:0] O_CBZ  = 11'b10110100101;

   typedef struct {
      logic [WORD-1:0] a;
      logic [WORD-1:0] b;
      logic [3:0]      ctl;
      logic            ill;
   } op_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [10:0]     opcode;
   logic [WORD-1:0] rn_data;
   logic [WORD-1:0] rm_data;
   logic [WORD-1:0] imm;
   logic            flush;
   logic            ex_valid;
   logic            ex_ready;
   logic [WORD-1:0] a_out;
   logic [WORD-1:0] b_out;
   logic [3:0]      alu_control;
   logic            illegal;
   logic [15:0]     issue_count;

   int          checks = 0;
   int          errors = 0;
   op_t         mq[$];
   logic [15:0] mcount = 16'd0;

   alu_issue #(.WORD(WORD)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rn_data(rn_data), .rm_data(rm_data), .imm(imm),
      .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .a_out(a_out), .b_out(b_out), .alu_control(alu_control),
      .illegal(illegal), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic op_t ref_decode(logic [10:0] opc, logic [WORD-1:0] rn,
                                      logic [WORD-1:0] rm, logic [WORD-1:0] im);
      op_t r;
      r.a = rn; r.b = rm; r.ill = 1'b0; r.ctl = C_PASS;
      if (opc == O_ADD) r.ctl = C_ADD;
      else if (opc == O_SUB) r.ctl = C_SUB;
      else if (opc == O_AND) r.ctl = C_AND;
      else if (opc == O_ORR) r.ctl = C_OR;
      else if (opc == O_LDUR || opc == O_STUR) begin r.ctl = C_ADD; r.b = im; end
      else if (opc[10:3] == 8'b10110100) r.ctl = C_PASS;
      else begin r.a = '0; r.b = '0; r.ill = 1'b1; end
      return r;
   endfunction

   function automatic op_t exp_head();
      op_t r;
      r.a = '0; r.b = '0; r.ctl = C_PASS; r.ill = 1'b0;
      if (mq.size() > 0) r = mq[0];
      return r;
   endfunction

   // Advance one clock; the model sees the same inputs the DUT samples at the edge.
   task automatic tick();
      bit out_f, in_f;
      if (!reset_n) begin
         mq.delete();
         mcount = 16'd0;
      end else begin
         out_f = (mq.size() > 0) && ex_ready;
         in_f  = in_valid && (mq.size() < 2) && !flush;
         if (out_f) begin
            void'(mq.pop_front());
            mcount = mcount + 16'd1;
         end
         if (flush) mq.delete();
         else if (in_f) mq.push_back(ref_decode(opcode, rn_data, rm_data, imm));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic present(logic [10:0] opc, logic [WORD-1:0] rn, logic [WORD-1:0] rm,
                          logic [WORD-1:0] im);
      in_valid = 1'b1; opcode = opc; rn_data = rn; rm_data = rm; imm = im;
   endtask

   task automatic drain();
      in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b1; ex_ready = 1'b1;
      present(O_ADD, 64'd7, 64'd9, 64'd0);
      repeat (2) tick();
      checks++;
      if ({ex_valid, in_ready, illegal, alu_control, issue_count} !== {1'b0, 1'b1, 1'b0, C_PASS, 16'd0}) begin
         errors++;
         $display("FAIL reset_ctl: got v=%b r=%b ill=%b ctl=%h cnt=%h, required v=0 r=1 ill=0 ctl=%h cnt=0",
                  ex_valid, in_ready, illegal, alu_control, issue_count, C_PASS);
      end
      checks++;
      if ({a_out, b_out} !== '0) begin
         errors++;
         $display("FAIL reset_data: got a=%h b=%h, required 0/0", a_out, b_out);
      end
      reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got r=%b v=%b, required r=1 v=0", in_ready, ex_valid);
      end
   endtask

   task automatic test_add();
      drain();
      ex_ready = 1'b1;
      present(O_ADD, 64'd5, 64'd3, 64'd99);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({ex_valid, alu_control, illegal} !== {1'b1, C_ADD, 1'b0} || a_out !== 64'd5 || b_out !== 64'd3) begin
         errors++;
         $display("FAIL add_issue: got v=%b ctl=%h a=%h b=%h, required v=1 ctl=%h a=5 b=3",
                  ex_valid, alu_control, a_out, b_out, C_ADD);
      end
      tick();
      checks++;
      if (issue_count !== mcount || ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_count: got cnt=%h v=%b, required cnt=%h v=0", issue_count, ex_valid, mcount);
      end
   endtask

   task automatic test_ldur_illegal();
      drain();
      ex_ready = 1'b0;
      present(O_LDUR, 64'h100, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      checks++;
      if (a_out !== 64'h100 || b_out !== 64'hFFFF_FFFF_FFFF_FFF8 || alu_control !== C_ADD || illegal !== 1'b0) begin
         errors++;
         $display("FAIL ldur: got a=%h b=%h ctl=%h ill=%b, required a=100 b=fffffffffffffff8 ctl=%h ill=0",
                  a_out, b_out, alu_control, illegal, C_ADD);
      end
      ex_ready = 1'b1;
      present(11'h7FF, 64'h1234, 64'h5678, 64'h9);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({ex_valid, illegal, alu_control} !== {1'b1, 1'b1, C_PASS} || a_out !== '0 || b_out !== '0) begin
         errors++;
         $display("FAIL illegal: got v=%b ill=%b ctl=%h a=%h b=%h, required v=1 ill=1 ctl=%h a=0 b=0",
                  ex_valid, illegal, alu_control, a_out, b_out, C_PASS);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] c0;
      drain();
      c0 = mcount;
      ex_ready = 1'b0;
      present(O_ADD, 64'd11, 64'd22, 64'd0);
      tick();
      present(O_SUB, 64'd33, 64'd44, 64'd0);
      tick();
      checks++;
      if (in_ready !== 1'b0 || a_out !== 64'd11 || b_out !== 64'd22 || alu_control !== C_ADD) begin
         errors++;
         $display("FAIL b2b_skid: got r=%b a=%h b=%h ctl=%h, required r=0 a=b b=16 ctl=%h",
                  in_ready, a_out, b_out, alu_control, C_ADD);
      end
      present(O_ORR, 64'd55, 64'd66, 64'd0);
      tick();
      checks++;
      if ({in_ready, ex_valid} !== 2'b01 || a_out !== 64'd11 || b_out !== 64'd22 || alu_control !== C_ADD) begin
         errors++;
         $display("FAIL b2b_hold: got r=%b v=%b a=%h b=%h ctl=%h, required r=0 v=1 a=b b=16 ctl=%h",
                  in_ready, ex_valid, a_out, b_out, alu_control, C_ADD);
      end
      ex_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || a_out !== 64'd33 || b_out !== 64'd44 || alu_control !== C_SUB) begin
         errors++;
         $display("FAIL b2b_second: got r=%b a=%h b=%h ctl=%h, required r=1 a=21 b=2c ctl=%h",
                  in_ready, a_out, b_out, alu_control, C_SUB);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (ex_valid !== 1'b1 || a_out !== 64'd55 || b_out !== 64'd66 || alu_control !== C_OR) begin
         errors++;
         $display("FAIL b2b_third: got v=%b a=%h b=%h ctl=%h, required v=1 a=37 b=42 ctl=%h",
                  ex_valid, a_out, b_out, alu_control, C_OR);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || issue_count !== c0 + 16'd3) begin
         errors++;
         $display("FAIL b2b_drain: got v=%b cnt=%h, required v=0 cnt=%h", ex_valid, issue_count, c0 + 16'd3);
      end
   endtask

   task automatic test_flush();
      logic [15:0] c0;
      drain();
      ex_ready = 1'b0;
      present(O_AND, 64'd1, 64'd2, 64'd0);
      tick();
      present(O_SUB, 64'd3, 64'd4, 64'd0);
      tick();
      flush = 1'b1;
      present(O_ADD, 64'd5, 64'd6, 64'd0);
      tick();
      flush = 1'b0;
      checks++;
      if ({ex_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL flush_clear: got v=%b r=%b, required v=0 r=1", ex_valid, in_ready);
      end
      ex_ready = 1'b1;
      present(O_STUR, 64'h200, 64'h77, 64'h10);
      tick();
      in_valid = 1'b0;
      checks++;
      if (ex_valid !== 1'b1 || a_out !== 64'h200 || b_out !== 64'h10 || alu_control !== C_ADD) begin
         errors++;
         $display("FAIL flush_after: got v=%b a=%h b=%h ctl=%h, required v=1 a=200 b=10 ctl=%h",
                  ex_valid, a_out, b_out, alu_control, C_ADD);
      end
      tick();
      ex_ready = 1'b0;
      present(O_CBZ, 64'd8, 64'd9, 64'd0);
      tick();
      present(O_ADD, 64'd10, 64'd11, 64'd0);
      tick();
      c0 = mcount;
      in_valid = 1'b0; flush = 1'b1; ex_ready = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (issue_count !== c0 + 16'd1 || ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_count: got cnt=%h v=%b, required cnt=%h v=0", issue_count, ex_valid, c0 + 16'd1);
      end
   endtask

   task automatic test_wrap();
      drain();
      ex_ready = 1'b1;
      present(O_ADD, 64'd1, 64'd1, 64'd0);
      for (int i = 0; i < 70000 && mcount != 16'hFFFF; i++) tick();
      checks++;
      if (issue_count !== 16'hFFFF || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pre: got cnt=%h v=%b, required cnt=ffff v=1", issue_count, ex_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (issue_count !== 16'h0000) begin
         errors++;
         $display("FAIL wrap: got cnt=%h, required cnt=0000", issue_count);
      end
   endtask

   task automatic test_reset_stall();
      drain();
      ex_ready = 1'b0;
      present(O_ORR, 64'd12, 64'd13, 64'd0);
      tick();
      present(11'h000, 64'd14, 64'd15, 64'd0);
      tick();
      reset_n = 1'b0; ex_ready = 1'b1;
      present(O_ADD, 64'd16, 64'd17, 64'd0);
      tick();
      checks++;
      if ({ex_valid, in_ready, illegal, alu_control, issue_count} !== {1'b0, 1'b1, 1'b0, C_PASS, 16'd0} ||
          a_out !== '0 || b_out !== '0) begin
         errors++;
         $display("FAIL reset_stall: got v=%b r=%b ill=%b ctl=%h cnt=%h a=%h b=%h, required v=0 r=1 ill=0 ctl=%h cnt=0 a=0 b=0",
                  ex_valid, in_ready, illegal, alu_control, issue_count, a_out, b_out, C_PASS);
      end
      reset_n = 1'b1; in_valid = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall_release: got r=%b v=%b, required r=1 v=0", in_ready, ex_valid);
      end
   endtask

   task automatic test_random();
      logic [10:0] table_ops [7];
      op_t e;
      table_ops = '{O_ADD, O_SUB, O_AND, O_ORR, O_LDUR, O_STUR, O_CBZ};
      for (int i = 0; i < 2000; i++) begin
         in_valid = ($urandom_range(3) != 0);
         ex_ready = ($urandom_range(2) != 0);
         flush    = ($urandom_range(19) == 0);
         opcode   = ($urandom_range(7) == 7) ? 11'($urandom) : table_ops[$urandom_range(6)];
         rn_data  = {$urandom, $urandom};
         rm_data  = {$urandom, $urandom};
         imm      = {$urandom, $urandom};
         tick();
         e = exp_head();
         checks++;
         if ({ex_valid, in_ready, illegal, alu_control, issue_count} !==
             {mq.size() > 0, mq.size() < 2, e.ill, e.ctl, mcount}) begin
            errors++;
            $display("FAIL rand_ctl[%0d]: got v=%b r=%b ill=%b ctl=%h cnt=%h, required v=%b r=%b ill=%b ctl=%h cnt=%h",
                     i, ex_valid, in_ready, illegal, alu_control, issue_count,
                     mq.size() > 0, mq.size() < 2, e.ill, e.ctl, mcount);
         end
         checks++;
         if (a_out !== e.a || b_out !== e.b) begin
            errors++;
            $display("FAIL rand_data[%0d]: got a=%h b=%h, required a=%h b=%h", i, a_out, b_out, e.a, e.b);
         end
      end
      flush = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; opcode = '0; rn_data = '0; rm_data = '0;
      imm = '0; flush = 1'b0; ex_ready = 1'b0;
      test_reset();
      test_add();
      test_ldur_illegal();
      test_back_to_back();
      test_flush();
      test_random();
      test_wrap();
      test_reset_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
